// File: rtl/control_pkg.sv
// Shared encodings and control-vector types for the RV32 control pipeline.
package control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

  localparam logic [1:0] A_SEL_RS1  = 2'b00;
  localparam logic [1:0] A_SEL_PC   = 2'b01;
  localparam logic [1:0] A_SEL_ZERO = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic [1:0] a_sel;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] mem_to_reg;
  } wb_ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/control_decode.sv
// Combinational RV32I opcode decoder producing the ID-stage control vector.
module control_decode
  import control_pkg::*;
#(
  parameter bit SUPPORT_JUMP  = 1'b1,
  parameter bit SUPPORT_UPPER = 1'b1
) (
  input  logic [6:0] opcode_i,
  input  logic       rd_zero_i,
  input  logic       valid_i,
  output ctrl_t      ctrl_o,
  output logic       rs1_used_o,
  output logic       rs2_used_o
);

  always_comb begin
    ctrl_o     = CTRL_BUBBLE;
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    if (valid_i) begin
      case (opcode_i)
        OP_R: begin
          ctrl_o.alu_op    = ALU_OP_RTYPE;
          ctrl_o.reg_write = 1'b1;
          rs1_used_o       = 1'b1;
          rs2_used_o       = 1'b1;
        end
        OP_IMM: begin
          ctrl_o.alu_op    = ALU_OP_ITYPE;
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.reg_write = 1'b1;
          rs1_used_o       = 1'b1;
        end
        OP_LOAD: begin
          ctrl_o.alu_op     = ALU_OP_ADD;
          ctrl_o.alu_src    = 1'b1;
          ctrl_o.mem_read   = 1'b1;
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.mem_to_reg = M2R_MEM;
          rs1_used_o        = 1'b1;
        end
        OP_STORE: begin
          ctrl_o.alu_op    = ALU_OP_ADD;
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.mem_write = 1'b1;
          rs1_used_o       = 1'b1;
          rs2_used_o       = 1'b1;
        end
        OP_BRANCH: begin
          ctrl_o.alu_op = ALU_OP_SUB;
          ctrl_o.branch = 1'b1;
          rs1_used_o    = 1'b1;
          rs2_used_o    = 1'b1;
        end
        OP_JAL: begin
          if (SUPPORT_JUMP) begin
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.a_sel      = A_SEL_PC;
            ctrl_o.jump       = 1'b1;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = M2R_PC4;
          end else begin
            ctrl_o.illegal = 1'b1;
          end
        end
        OP_JALR: begin
          if (SUPPORT_JUMP) begin
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.a_sel      = A_SEL_RS1;
            ctrl_o.jump       = 1'b1;
            ctrl_o.jalr       = 1'b1;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = M2R_PC4;
            rs1_used_o        = 1'b1;
          end else begin
            ctrl_o.illegal = 1'b1;
          end
        end
        OP_LUI: begin
          if (SUPPORT_UPPER) begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.a_sel     = A_SEL_ZERO;
            ctrl_o.reg_write = 1'b1;
          end else begin
            ctrl_o.illegal = 1'b1;
          end
        end
        OP_AUIPC: begin
          if (SUPPORT_UPPER) begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.a_sel     = A_SEL_PC;
            ctrl_o.reg_write = 1'b1;
          end else begin
            ctrl_o.illegal = 1'b1;
          end
        end
        default: ctrl_o.illegal = 1'b1;
      endcase
      // Writes to x0 are architecturally discarded; dropping them here also keeps forwarding quiet.
      if (rd_zero_i) begin
        ctrl_o.reg_write = 1'b0;
      end
    end
  end

endmodule

// File: rtl/control_pipeline.sv
// Control path for the 5-stage RV32 core: decode, load-use stall, redirect flush, EX/MEM/WB regs.
module control_pipeline
  import control_pkg::*;
#(
  parameter int unsigned REG_ADDR_W    = 5,
  parameter bit          SUPPORT_JUMP  = 1'b1,
  parameter bit          SUPPORT_UPPER = 1'b1,
  parameter bit          HAZARD_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           id_instr,
  input  logic                  id_valid,
  input  logic                  ex_redirect,
  output logic                  hazard_stall,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_alu_src,
  output logic [1:0]            ex_alu_a_sel,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_jalr,
  output logic                  ex_mem_read,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_reg_write,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_reg_write,
  output logic [1:0]            wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  ex_illegal
);

  logic [REG_ADDR_W-1:0] id_rd, id_rs1, id_rs2;
  ctrl_t                 id_ctrl;
  logic                  id_rs1_used, id_rs2_used, rs_match;

  ctrl_t                 ex_ctrl_d, ex_ctrl_q;
  logic [REG_ADDR_W-1:0] ex_rd_d, ex_rd_q;
  mem_ctrl_t             mem_ctrl_d, mem_ctrl_q;
  logic [REG_ADDR_W-1:0] mem_rd_d, mem_rd_q;
  wb_ctrl_t              wb_ctrl_d, wb_ctrl_q;
  logic [REG_ADDR_W-1:0] wb_rd_d, wb_rd_q;

  logic unused_funct;
  assign unused_funct = ^{id_instr[14:12], id_instr[31:25]};

  assign id_rd  = id_instr[7 +: REG_ADDR_W];
  assign id_rs1 = id_instr[15 +: REG_ADDR_W];
  assign id_rs2 = id_instr[20 +: REG_ADDR_W];

  control_decode #(
    .SUPPORT_JUMP  (SUPPORT_JUMP),
    .SUPPORT_UPPER (SUPPORT_UPPER)
  ) u_decode (
    .opcode_i   (id_instr[6:0]),
    .rd_zero_i  (id_rd == '0),
    .valid_i    (id_valid),
    .ctrl_o     (id_ctrl),
    .rs1_used_o (id_rs1_used),
    .rs2_used_o (id_rs2_used)
  );

  // A redirect squashes the ID instruction anyway, so stalling behind it would waste a cycle.
  always_comb begin
    rs_match     = (id_rs1_used && (ex_rd_q == id_rs1)) || (id_rs2_used && (ex_rd_q == id_rs2));
    hazard_stall = HAZARD_EN && id_valid && ex_ctrl_q.mem_read && (ex_rd_q != '0) && rs_match &&
                   !ex_redirect;
  end

  always_comb begin
    ex_ctrl_d = CTRL_BUBBLE;
    ex_rd_d   = '0;
    if (!(ex_redirect || hazard_stall)) begin
      ex_ctrl_d = id_ctrl;
      ex_rd_d   = (id_valid && !id_ctrl.illegal) ? id_rd : '0;
    end
    mem_ctrl_d.mem_read   = ex_ctrl_q.mem_read;
    mem_ctrl_d.mem_write  = ex_ctrl_q.mem_write;
    mem_ctrl_d.reg_write  = ex_ctrl_q.reg_write;
    mem_ctrl_d.mem_to_reg = ex_ctrl_q.mem_to_reg;
    mem_rd_d              = ex_rd_q;
    wb_ctrl_d.reg_write   = mem_ctrl_q.reg_write;
    wb_ctrl_d.mem_to_reg  = mem_ctrl_q.mem_to_reg;
    wb_rd_d               = mem_rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl_q  <= CTRL_BUBBLE;
      ex_rd_q    <= '0;
      mem_ctrl_q <= '0;
      mem_rd_q   <= '0;
      wb_ctrl_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rd_q    <= ex_rd_d;
      mem_ctrl_q <= mem_ctrl_d;
      mem_rd_q   <= mem_rd_d;
      wb_ctrl_q  <= wb_ctrl_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  assign ex_alu_op     = ex_ctrl_q.alu_op;
  assign ex_alu_src    = ex_ctrl_q.alu_src;
  assign ex_alu_a_sel  = ex_ctrl_q.a_sel;
  assign ex_branch     = ex_ctrl_q.branch;
  assign ex_jump       = ex_ctrl_q.jump;
  assign ex_jalr       = ex_ctrl_q.jalr;
  assign ex_mem_read   = ex_ctrl_q.mem_read;
  assign ex_rd         = ex_rd_q;
  assign ex_illegal    = ex_ctrl_q.illegal;
  assign mem_mem_read  = mem_ctrl_q.mem_read;
  assign mem_mem_write = mem_ctrl_q.mem_write;
  assign mem_reg_write = mem_ctrl_q.reg_write;
  assign mem_rd        = mem_rd_q;
  assign wb_reg_write  = wb_ctrl_q.reg_write;
  assign wb_mem_to_reg = wb_ctrl_q.mem_to_reg;
  assign wb_rd         = wb_rd_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: reset, load-use stall, x0 loads, redirect, jumps, illegal.
module tb_control_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        ex_redirect;

  logic       hazard_stall, ex_alu_src, ex_branch, ex_jump, ex_jalr, ex_mem_read, ex_illegal;
  logic [1:0] ex_alu_op, ex_alu_a_sel, wb_mem_to_reg;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       mem_mem_read, mem_mem_write, mem_reg_write, wb_reg_write;

  logic       n_hazard_stall, n_ex_alu_src, n_ex_branch, n_ex_jump, n_ex_jalr, n_ex_mem_read;
  logic       n_ex_illegal, n_mem_mem_read, n_mem_mem_write, n_mem_reg_write, n_wb_reg_write;
  logic [1:0] n_ex_alu_op, n_ex_alu_a_sel, n_wb_mem_to_reg;
  logic [4:0] n_ex_rd, n_mem_rd, n_wb_rd;

  logic [31:0] all_outs, n_all_outs;
  logic [14:0] ex_vec;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  control_pipeline u_dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .ex_redirect(ex_redirect),
    .hazard_stall(hazard_stall), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_alu_a_sel(ex_alu_a_sel), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
    .ex_illegal(ex_illegal)
  );

  control_pipeline #(.SUPPORT_UPPER(1'b0)) u_noup (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .ex_redirect(ex_redirect),
    .hazard_stall(n_hazard_stall), .ex_alu_op(n_ex_alu_op), .ex_alu_src(n_ex_alu_src),
    .ex_alu_a_sel(n_ex_alu_a_sel), .ex_branch(n_ex_branch), .ex_jump(n_ex_jump),
    .ex_jalr(n_ex_jalr), .ex_mem_read(n_ex_mem_read), .ex_rd(n_ex_rd),
    .mem_mem_read(n_mem_mem_read), .mem_mem_write(n_mem_mem_write),
    .mem_reg_write(n_mem_reg_write), .mem_rd(n_mem_rd), .wb_reg_write(n_wb_reg_write),
    .wb_mem_to_reg(n_wb_mem_to_reg), .wb_rd(n_wb_rd), .ex_illegal(n_ex_illegal)
  );

  assign all_outs = {hazard_stall, ex_alu_op, ex_alu_src, ex_alu_a_sel, ex_branch, ex_jump,
                     ex_jalr, ex_mem_read, ex_rd, mem_mem_read, mem_mem_write, mem_reg_write,
                     mem_rd, wb_reg_write, wb_mem_to_reg, wb_rd, ex_illegal};
  assign n_all_outs = {n_hazard_stall, n_ex_alu_op, n_ex_alu_src, n_ex_alu_a_sel, n_ex_branch,
                       n_ex_jump, n_ex_jalr, n_ex_mem_read, n_ex_rd, n_mem_mem_read,
                       n_mem_mem_write, n_mem_reg_write, n_mem_rd, n_wb_reg_write,
                       n_wb_mem_to_reg, n_wb_rd, n_ex_illegal};
  assign ex_vec = {ex_alu_op, ex_alu_src, ex_alu_a_sel, ex_branch, ex_jump, ex_jalr,
                   ex_mem_read, ex_rd, ex_illegal};

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    id_valid    = 1'b0;
    ex_redirect = 1'b0;
    id_instr    = 32'h0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    ex_redirect = 1'b0;
    id_valid    = 1'b1;
    id_instr    = $urandom;
    step();
    id_instr = $urandom;
    step();
    checks++;
    if (all_outs !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 00000000", all_outs);
    end
    checks++;
    if (n_all_outs !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs_noup: got %h expected 00000000", n_all_outs);
    end
    id_valid = 1'b0;
    rst      = 1'b0;
    step();
  endtask

  task automatic test_load_use();
    drain();
    id_valid = 1'b1;
    id_instr = enc_i(7'b0000011, 5'd5, 5'd1, 3'b010, 12'd0);
    step();
    checks++;
    if (ex_mem_read !== 1'b1) begin
      errors++;
      $display("FAIL lu_ex_mem_read: got %b expected 1", ex_mem_read);
    end
    id_instr = enc_r(5'd6, 5'd5, 5'd7);
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall: got %b expected 1", hazard_stall);
    end
    step();
    checks++;
    if (ex_vec !== 15'h0) begin
      errors++;
      $display("FAIL lu_bubble: got %h expected 0000", ex_vec);
    end
    checks++;
    if ({mem_mem_read, mem_rd} !== {1'b1, 5'd5}) begin
      errors++;
      $display("FAIL lu_mem_stage: got %b/%0d expected 1/5", mem_mem_read, mem_rd);
    end
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_stall_release: got %b expected 0", hazard_stall);
    end
    step();
    checks++;
    if ({ex_alu_op, ex_alu_src, ex_rd} !== {2'b10, 1'b0, 5'd6}) begin
      errors++;
      $display("FAIL lu_add_in_ex: got op=%b src=%b rd=%0d expected op=10 src=0 rd=6",
               ex_alu_op, ex_alu_src, ex_rd);
    end
    checks++;
    if ({wb_reg_write, wb_mem_to_reg, wb_rd} !== {1'b1, 2'b01, 5'd5}) begin
      errors++;
      $display("FAIL lu_load_wb: got rw=%b m2r=%b rd=%0d expected rw=1 m2r=01 rd=5",
               wb_reg_write, wb_mem_to_reg, wb_rd);
    end
  endtask

  task automatic test_load_x0();
    drain();
    id_valid = 1'b1;
    id_instr = enc_i(7'b0000011, 5'd0, 5'd2, 3'b010, 12'd4);
    step();
    id_instr = enc_r(5'd6, 5'd0, 5'd1);
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL x0_no_stall: got %b expected 0", hazard_stall);
    end
    step();
    checks++;
    if ({ex_alu_op, ex_rd} !== {2'b10, 5'd6}) begin
      errors++;
      $display("FAIL x0_add_in_ex: got op=%b rd=%0d expected op=10 rd=6", ex_alu_op, ex_rd);
    end
    id_valid = 1'b0;
    step();
    checks++;
    if ({wb_reg_write, wb_mem_to_reg} !== {1'b0, 2'b01}) begin
      errors++;
      $display("FAIL x0_load_wb: got rw=%b m2r=%b expected rw=0 m2r=01",
               wb_reg_write, wb_mem_to_reg);
    end
  endtask

  task automatic test_redirect();
    drain();
    id_valid = 1'b1;
    id_instr = {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
    step();
    checks++;
    if ({ex_branch, ex_alu_op, ex_alu_src} !== {1'b1, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL rd_beq_ex: got br=%b op=%b src=%b expected br=1 op=01 src=0",
               ex_branch, ex_alu_op, ex_alu_src);
    end
    id_instr    = enc_i(7'b0010011, 5'd3, 5'd1, 3'b000, 12'd5);
    ex_redirect = 1'b1;
    step();
    checks++;
    if (ex_vec !== 15'h0) begin
      errors++;
      $display("FAIL rd_flush: got %h expected 0000", ex_vec);
    end
    ex_redirect = 1'b0;
    step();
    checks++;
    if ({ex_alu_op, ex_alu_src, ex_rd} !== {2'b11, 1'b1, 5'd3}) begin
      errors++;
      $display("FAIL rd_addi_ex: got op=%b src=%b rd=%0d expected op=11 src=1 rd=3",
               ex_alu_op, ex_alu_src, ex_rd);
    end
    id_instr = enc_i(7'b0000011, 5'd5, 5'd1, 3'b010, 12'd0);
    step();
    id_instr    = enc_r(5'd6, 5'd5, 5'd7);
    ex_redirect = 1'b1;
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL rd_stall_masked: got %b expected 0", hazard_stall);
    end
    step();
    checks++;
    if (ex_vec !== 15'h0) begin
      errors++;
      $display("FAIL rd_single_bubble: got %h expected 0000", ex_vec);
    end
    ex_redirect = 1'b0;
    id_valid    = 1'b0;
  endtask

  task automatic test_jal();
    drain();
    id_valid = 1'b1;
    id_instr = {20'd0, 5'd1, 7'b1101111};
    step();
    checks++;
    if ({ex_jump, ex_jalr, ex_alu_a_sel, ex_alu_src} !== {1'b1, 1'b0, 2'b01, 1'b1}) begin
      errors++;
      $display("FAIL jal_ex: got j=%b jr=%b asel=%b src=%b expected j=1 jr=0 asel=01 src=1",
               ex_jump, ex_jalr, ex_alu_a_sel, ex_alu_src);
    end
    id_valid = 1'b0;
    step();
    step();
    checks++;
    if ({wb_reg_write, wb_mem_to_reg, wb_rd} !== {1'b1, 2'b10, 5'd1}) begin
      errors++;
      $display("FAIL jal_wb: got rw=%b m2r=%b rd=%0d expected rw=1 m2r=10 rd=1",
               wb_reg_write, wb_mem_to_reg, wb_rd);
    end
    id_valid = 1'b1;
    id_instr = enc_i(7'b1100111, 5'd2, 5'd1, 3'b000, 12'd0);
    step();
    checks++;
    if ({ex_jump, ex_jalr, ex_alu_a_sel} !== {1'b1, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL jalr_ex: got j=%b jr=%b asel=%b expected j=1 jr=1 asel=00",
               ex_jump, ex_jalr, ex_alu_a_sel);
    end
    id_valid = 1'b0;
  endtask

  task automatic test_illegal();
    drain();
    id_valid = 1'b1;
    id_instr = 32'h0000_0073;
    step();
    checks++;
    if (ex_vec !== 15'h0001) begin
      errors++;
      $display("FAIL ill_system: got %h expected 0001", ex_vec);
    end
    id_instr = {20'h12345, 5'd3, 7'b0110111};
    step();
    checks++;
    if ({ex_alu_a_sel, ex_alu_src, ex_illegal, ex_rd} !== {2'b10, 1'b1, 1'b0, 5'd3}) begin
      errors++;
      $display("FAIL lui_ex: got asel=%b src=%b ill=%b rd=%0d expected asel=10 src=1 ill=0 rd=3",
               ex_alu_a_sel, ex_alu_src, ex_illegal, ex_rd);
    end
    checks++;
    if ({n_ex_illegal, n_ex_alu_src, n_ex_alu_a_sel} !== {1'b1, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL lui_noup: got ill=%b src=%b asel=%b expected ill=1 src=0 asel=00",
               n_ex_illegal, n_ex_alu_src, n_ex_alu_a_sel);
    end
    id_instr = {20'h00001, 5'd4, 7'b0010111};
    step();
    checks++;
    if ({ex_alu_a_sel, ex_illegal, n_ex_illegal} !== {2'b01, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL auipc_ex: got asel=%b ill=%b noup_ill=%b expected asel=01 ill=0 noup_ill=1",
               ex_alu_a_sel, ex_illegal, n_ex_illegal);
    end
    id_valid = 1'b0;
    id_instr = 32'h0000_0073;
    step();
    checks++;
    if (ex_illegal !== 1'b0) begin
      errors++;
      $display("FAIL ill_bubble_in: got %b expected 0", ex_illegal);
    end
  endtask

  task automatic test_reset_midstream();
    drain();
    id_valid = 1'b1;
    id_instr = enc_i(7'b0000011, 5'd9, 5'd1, 3'b010, 12'd0);
    step();
    id_valid = 1'b0;
    rst      = 1'b1;
    step();
    checks++;
    if (all_outs !== 32'h0) begin
      errors++;
      $display("FAIL reset_midstream: got %h expected 00000000", all_outs);
    end
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst         = 1'b1;
    id_valid    = 1'b0;
    id_instr    = 32'h0;
    ex_redirect = 1'b0;
    test_reset();
    test_load_use();
    test_load_x0();
    test_redirect();
    test_jal();
    test_illegal();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
